// File: rtl/param_rr_mux.sv
// param_rr_mux: N-channel to 1 multiplexer with a registered output stage.
// Channel choice is either a fixed index (mode=0) or round-robin starting
// from a rotating pointer (mode=1). Upstream handshake is combinational.
// The output register drains and reloads in the same cycle.
module param_rr_mux #(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    localparam int SW   = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [SW-1:0]        sel,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SW-1:0]        out_src,
    input  logic                 out_ready
);

    // Registered output word and the channel that produced it.
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SW-1:0]    src;
    } out_t;

    // vld_pipe[0]: a transfer this cycle; vld_pipe[1]: output register holds a word.
    logic [1:0]                  vld_pipe;
    out_t                        oreg;
    logic [SW-1:0]               ptr;

    logic                        adv;
    logic                        sel_ok;
    logic [N-1:0]                rot;
    logic                        rr_hit;
    logic [SW-1:0]               rr_off;
    logic [SW:0]                 wsum;
    logic [SW-1:0]               rr_idx;
    logic [SW-1:0]               gnt_idx;
    logic [SW-1:0]               ptr_nxt;
    logic [N-1:0]                cand;
    logic [N-1:0][WIDTH-1:0]     lane_data;
    logic [N-1:0][WIDTH-1:0]     lane_gated;
    logic [WIDTH-1:0]            mux_data;

    // Output register may load when empty or being drained; reset blocks all grants.
    assign adv    = (!vld_pipe[1] || out_ready) && !rst;
    // Out-of-range select (only possible for non-power-of-two N) grants nobody.
    assign sel_ok = ({1'b0, sel} < (SW+1)'(N));

    // Round-robin search: rotate valids so bit 0 is channel ptr, take the lowest set bit.
    always_comb begin
        rot    = N'({in_valid, in_valid} >> ptr);
        rr_hit = 1'b0;
        rr_off = '0;
        for (int k = N-1; k >= 0; k--) begin
            if (rot[k]) begin
                rr_hit = 1'b1;
                rr_off = SW'(k);
            end
        end
        wsum = {1'b0, ptr} + {1'b0, rr_off};
        if (wsum >= (SW+1)'(N))
            wsum = wsum - (SW+1)'(N);
        rr_idx = wsum[SW-1:0];
    end

    // Per-channel candidate flag, data slice and handshake lane.
    for (genvar i = 0; i < N; i++) begin : g_lane
        assign cand[i]      = mode ? (rr_hit && (rr_idx == SW'(i)))
                                   : (sel_ok && (sel == SW'(i)));
        assign lane_data[i] = in_data[i*WIDTH +: WIDTH];

        param_rr_mux_lane #(.WIDTH(WIDTH)) u_lane (
            .adv   (adv),
            .cand  (cand[i]),
            .valid (in_valid[i]),
            .data  (lane_data[i]),
            .ready (in_ready[i]),
            .gated (lane_gated[i])
        );
    end

    // AND-OR data mux: at most one lane passes its word through.
    always_comb begin
        mux_data = '0;
        for (int i = 0; i < N; i++)
            mux_data = mux_data | lane_gated[i];
    end

    assign vld_pipe[0] = |in_ready;
    assign gnt_idx     = mode ? rr_idx : sel;
    assign ptr_nxt     = (rr_idx == SW'(N-1)) ? '0 : rr_idx + SW'(1);

    // Output register: load on transfer, clear valid on an idle advance, hold on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe[1] <= 1'b0;
            oreg        <= '0;
        end else if (adv) begin
            vld_pipe[1] <= vld_pipe[0];
            if (vld_pipe[0]) begin
                oreg.data <= mux_data;
                oreg.src  <= gnt_idx;
            end
        end
    end

    // Round-robin pointer moves past the winner only on round-robin transfers.
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (vld_pipe[0] && mode)
            ptr <= ptr_nxt;
    end

    assign out_valid = vld_pipe[1];
    assign out_data  = oreg.data;
    assign out_src   = oreg.src;

endmodule

// One channel's handshake: accept when it is the candidate, valid, and the
// output stage can advance; forward its data only when accepted.
module param_rr_mux_lane #(
    parameter int WIDTH = 16
) (
    input  logic             adv,
    input  logic             cand,
    input  logic             valid,
    input  logic [WIDTH-1:0] data,
    output logic             ready,
    output logic [WIDTH-1:0] gated
);

    assign ready = adv && cand && valid;
    assign gated = data & {WIDTH{ready}};

endmodule
